execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe_if.sv | 42 ++++
 rtl/execute_pipe.sv | 142 ++++++++++++++
 tb/tb_execute_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: execute-stage inputs and memory-stage outputs of execute_pipe.
// The slave modport is the pipeline stage; master is whoever drives decode/execute.
interface execute_pipe_if;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [3:0]  WA3E;
    logic        PCSrcE;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic        FlagWriteE;
    logic [2:0]  ALUControlE;
    logic [3:0]  CondE;
    logic        StallM;
    logic        FlushM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  WA3M;
    logic        PCSrcM;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [3:0]  FlagsOut;

    modport slave (
        input  RD1E, RD2E, ImmExtE, WA3E,
        input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagWriteE,
        input  ALUControlE, CondE, StallM, FlushM,
        output ALUResultM, WriteDataM, WA3M,
        output PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsOut
    );

    modport master (
        output RD1E, RD2E, ImmExtE, WA3E,
        output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagWriteE,
        output ALUControlE, CondE, StallM, FlushM,
        input  ALUResultM, WriteDataM, WA3M,
        input  PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsOut
    );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: ARM-style execute stage -- ALU, NZCV flag register and the
// execute/memory pipeline register with stall and flush.
// Conditional execution is compiled in only when EXEC_COND_EN is defined;
// without it every instruction executes and CondE is ignored.
module execute_pipe (
    input logic           clk,
    input logic           reset,
    execute_pipe_if.slave bus
);
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [32:0] sum;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  flags_new;
    logic        cond_ex;
    logic        flag_we;

    logic [3:0]  flags_q;
    logic [31:0] alu_result_q;
    logic [31:0] write_data_q;
    logic [3:0]  wa3_q;
    logic        pcsrc_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic        memwrite_q;

    // ALU and candidate flags; C and V carry over unless the op is ADD/SUB
    always_comb begin
        src_a      = bus.RD1E;
        src_b      = bus.ALUSrcE ? bus.ImmExtE : bus.RD2E;
        sum        = 33'd0;
        alu_result = 32'd0;
        flag_c     = flags_q[1];
        flag_v     = flags_q[0];
        case (bus.ALUControlE)
            3'b000: begin
                sum        = {1'b0, src_a} + {1'b0, src_b};
                alu_result = sum[31:0];
                flag_c     = sum[32];
                flag_v     = (src_a[31] == src_b[31]) && (alu_result[31] != src_a[31]);
            end
            3'b001: begin
                // A + ~B + 1 so the carry-out reads as "no borrow"
                sum        = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
                alu_result = sum[31:0];
                flag_c     = sum[32];
                flag_v     = (src_a[31] != src_b[31]) && (alu_result[31] != src_a[31]);
            end
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            3'b101: alu_result = src_b;
            3'b110: alu_result = src_a << src_b[4:0];
            3'b111: alu_result = src_a >> src_b[4:0];
        endcase
        flags_new = {alu_result[31], alu_result == 32'd0, flag_c, flag_v};
    end

`ifdef EXEC_COND_EN
    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    // Condition check against the flags as they stand before this instruction
    always_comb begin
        cond_ex = 1'b1;
        case (bus.CondE)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            default: cond_ex = 1'b1;
        endcase
    end
`else
    logic unused_cond;

    assign unused_cond = ^bus.CondE;
    assign cond_ex     = 1'b1;
`endif

    assign flag_we = bus.FlagWriteE & cond_ex & ~bus.StallM & ~bus.FlushM;

    // NZCV register: written only by an advancing, condition-passing flag setter
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flag_we) begin
            flags_q <= flags_new;
        end
    end

    // Execute/memory register: flush bubbles the controls, stall holds everything
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            wa3_q        <= 4'd0;
            pcsrc_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            memwrite_q   <= 1'b0;
        end else if (bus.FlushM) begin
            pcsrc_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            memwrite_q   <= 1'b0;
        end else if (!bus.StallM) begin
            alu_result_q <= alu_result;
            write_data_q <= bus.RD2E;
            wa3_q        <= bus.WA3E;
            pcsrc_q      <= bus.PCSrcE & cond_ex;
            regwrite_q   <= bus.RegWriteE & cond_ex;
            memtoreg_q   <= bus.MemtoRegE;
            memwrite_q   <= bus.MemWriteE & cond_ex;
        end
    end

    assign bus.ALUResultM = alu_result_q;
    assign bus.WriteDataM = write_data_q;
    assign bus.WA3M       = wa3_q;
    assign bus.PCSrcM     = pcsrc_q;
    assign bus.RegWriteM  = regwrite_q;
    assign bus.MemtoRegM  = memtoreg_q;
    assign bus.MemWriteM  = memwrite_q;
    assign bus.FlagsOut   = flags_q;
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: table-driven ALU/flag vectors plus directed sequences for
// conditional execution, stall, flush and reset. Expectations follow the
// EXEC_COND_EN setting of the build.
module tb_execute_pipe;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

`ifdef EXEC_COND_EN
    localparam bit CondEn = 1'b1;
`else
    localparam bit CondEn = 1'b0;
`endif

    execute_pipe_if bus ();

    execute_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        src;
        logic        fw;
        logic [3:0]  wa3;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic src, input logic fw,
                         input logic [3:0] cond, input logic rw, input logic mw,
                         input logic pcs, input logic mtr, input logic [3:0] wa3);
        bus.ALUControlE = op;
        bus.RD1E        = a;
        bus.RD2E        = rd2;
        bus.ImmExtE     = imm;
        bus.ALUSrcE     = src;
        bus.FlagWriteE  = fw;
        bus.CondE       = cond;
        bus.RegWriteE   = rw;
        bus.MemWriteE   = mw;
        bus.PCSrcE      = pcs;
        bus.MemtoRegE   = mtr;
        bus.WA3E        = wa3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ALUResultM"}, bus.ALUResultM, 32'd0);
        check({tag, " WriteDataM"}, bus.WriteDataM, 32'd0);
        check({tag, " WA3M"},       {28'd0, bus.WA3M}, 32'd0);
        check({tag, " ctrl"},
              {28'd0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'd0);
        check({tag, " FlagsOut"},   {28'd0, bus.FlagsOut}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //           op      a             rd2           imm           src   fw    wa3  result        NZCV
        vecs[0]  = '{3'b001, 32'd5,        32'd5,        32'd0,        1'b0, 1'b1, 4'd1, 32'h00000000, 4'b0110};
        vecs[1]  = '{3'b000, 32'h7FFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 4'd2, 32'h80000000, 4'b1001};
        vecs[2]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        1'b0, 1'b1, 4'd3, 32'h00F000F0, 4'b0001};
        vecs[3]  = '{3'b011, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b1, 4'd4, 32'h80000001, 4'b1001};
        vecs[4]  = '{3'b100, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'd0,        1'b0, 1'b1, 4'd5, 32'h00000000, 4'b0101};
        vecs[5]  = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 4'd6, 32'h00000000, 4'b0110};
        vecs[6]  = '{3'b001, 32'd3,        32'd5,        32'd0,        1'b0, 1'b1, 4'd7, 32'hFFFFFFFE, 4'b1000};
        vecs[7]  = '{3'b101, 32'h11111111, 32'hDEAD0000, 32'h00000123, 1'b1, 1'b1, 4'd8, 32'h00000123, 4'b0000};
        vecs[8]  = '{3'b001, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b1, 4'd9, 32'h7FFFFFFF, 4'b0011};
        vecs[9]  = '{3'b110, 32'd3,        32'h00000021, 32'd0,        1'b0, 1'b1, 4'd10, 32'h00000006, 4'b0011};
        vecs[10] = '{3'b111, 32'h80000000, 32'h00000055, 32'd4,        1'b1, 1'b1, 4'd11, 32'h08000000, 4'b0011};
        vecs[11] = '{3'b110, 32'd1,        32'd31,       32'd0,        1'b0, 1'b1, 4'd12, 32'h80000000, 4'b1011};
        vecs[12] = '{3'b000, 32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 4'd13, 32'h00000003, 4'b1011};

        // Reset state
        reset      = 1'b1;
        bus.StallM = 1'b0;
        bus.FlushM = 1'b0;
        drive(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // ALU ops and flags, always-execute condition
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].rd2, vecs[i].imm, vecs[i].src, vecs[i].fw,
                  4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].wa3);
            tick();
            check($sformatf("vec%0d ALUResultM", i), bus.ALUResultM, vecs[i].exp_res);
            check($sformatf("vec%0d WriteDataM", i), bus.WriteDataM, vecs[i].rd2);
            check($sformatf("vec%0d WA3M", i), {28'd0, bus.WA3M}, {28'd0, vecs[i].wa3});
            check($sformatf("vec%0d FlagsOut", i), {28'd0, bus.FlagsOut}, {28'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d RegWriteM", i), {31'd0, bus.RegWriteM}, 32'd1);
        end

        // Condition NE after Z=1; the flag write is suppressed when conditional
        drive(3'b001, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        check("setZ FlagsOut", {28'd0, bus.FlagsOut}, 32'h6);
        drive(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        check("NE RegWriteM", {31'd0, bus.RegWriteM}, CondEn ? 32'd0 : 32'd1);
        check("NE MemWriteM", {31'd0, bus.MemWriteM}, CondEn ? 32'd0 : 32'd1);
        check("NE PCSrcM", {31'd0, bus.PCSrcM}, CondEn ? 32'd0 : 32'd1);
        check("NE MemtoRegM", {31'd0, bus.MemtoRegM}, 32'd1);
        check("NE FlagsOut", {28'd0, bus.FlagsOut}, CondEn ? 32'h6 : 32'h0);
        check("NE ALUResultM", bus.ALUResultM, 32'd2);
        drive(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check("EQ RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);

        // Same-cycle flag write: condition uses old Z, new flags gate the next one
        drive(3'b001, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        drive(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        tick();
        check("EQ+fw RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
        check("EQ+fw FlagsOut", {28'd0, bus.FlagsOut}, 32'h0);
        drive(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        tick();
        check("EQ-after RegWriteM", {31'd0, bus.RegWriteM}, CondEn ? 32'd0 : 32'd1);

        // Stall for two cycles while inputs change, then release
        drive(3'b000, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check("pre-stall ALUResultM", bus.ALUResultM, 32'd30);
        check("pre-stall FlagsOut", {28'd0, bus.FlagsOut}, 32'h0);
        bus.StallM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(3'b001, 32'd5 + i, 32'd5 + i, 32'd0, 1'b0, 1'b1, 4'b1110,
                  1'b0, 1'b1, 1'b1, 1'b1, 4'd7 + i[3:0]);
            tick();
            check($sformatf("stall%0d ALUResultM", i), bus.ALUResultM, 32'd30);
            check($sformatf("stall%0d WriteDataM", i), bus.WriteDataM, 32'd20);
            check($sformatf("stall%0d WA3M", i), {28'd0, bus.WA3M}, 32'd3);
            check($sformatf("stall%0d ctrl", i),
                  {28'd0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'h4);
            check($sformatf("stall%0d FlagsOut", i), {28'd0, bus.FlagsOut}, 32'h0);
        end
        bus.StallM = 1'b0;
        tick();
        check("release ALUResultM", bus.ALUResultM, 32'd0);
        check("release WA3M", {28'd0, bus.WA3M}, 32'd8);
        check("release ctrl",
              {28'd0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'hB);
        check("release FlagsOut", {28'd0, bus.FlagsOut}, 32'h6);

        // Flush wins over stall: controls cleared, data held, flags untouched
        bus.StallM = 1'b1;
        bus.FlushM = 1'b1;
        drive(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        tick();
        check("flush ctrl",
              {28'd0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'h0);
        check("flush FlagsOut", {28'd0, bus.FlagsOut}, 32'h6);
        check("flush ALUResultM", bus.ALUResultM, 32'd0);
        check("flush WA3M", {28'd0, bus.WA3M}, 32'd8);
        bus.StallM = 1'b0;
        bus.FlushM = 1'b0;

        // Reset mid-stream with stall held
        drive(3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
        tick();
        check("pre-reset ALUResultM", bus.ALUResultM, 32'd3);
        bus.StallM = 1'b1;
        reset      = 1'b1;
        tick();
        check_all_zero("midreset");
        reset      = 1'b0;
        bus.StallM = 1'b0;

        // NE after Z=1 once more from a clean reset
        drive(3'b001, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        drive(3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        check("post-reset NE RegWriteM", {31'd0, bus.RegWriteM}, CondEn ? 32'd0 : 32'd1);
        check("post-reset FlagsOut", {28'd0, bus.FlagsOut}, 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
